// File: rtl/clock_pkg.sv
// Shared constants for the BCD clock setting interface.
// State encoding and set_clk pulse shape used by the core and its bench.
package clock_pkg;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HOUR = 2'd1;
  localparam logic [1:0] S_MIN  = 2'd2;
  localparam logic [1:0] S_SEC  = 2'd3;

  localparam int SET_PULSE_HI  = 2;
  localparam int SET_PULSE_GAP = 2;

  function automatic logic [1:0] next_state(input logic [1:0] s);
    logic [1:0] n;
    n = S_RUN;
    case (s)
      S_RUN:   n = S_HOUR;
      S_HOUR:  n = S_MIN;
      S_MIN:   n = S_SEC;
      default: n = S_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: level follows raw after DEB_CYC stable cycles.
// rise flags the edge on which the debounced level goes 0->1.
module key_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (raw != db) && (cnt == CW'(DEB_CYC - 1));
  assign rise = flip && raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (raw == db) begin
      cnt <= '0;
    end else if (flip) begin
      db  <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Setting sequencer for the 24h BCD clock core: mode FSM, increment
// strobes with hold-to-repeat, inactivity timeout and field blink.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYC     = 20,
  parameter int HOLD_CYC    = 500,
  parameter int REP_CYC     = 200,
  parameter int TIMEOUT_CYC = 30000,
  parameter int BLINK_HALF  = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic key_mode,
  input  logic key_inc,
  output logic set_clr,
  output logic set_hour,
  output logic set_min,
  output logic set_sec,
  output logic set_clk,
  output logic blink
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(REP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int PW = $clog2(SET_PULSE_HI + SET_PULSE_GAP);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          db_mode;
  logic          db_inc;
  logic          mode_rise;
  logic          inc_rise;
  logic          mode_pend;
  logic          chg_q;
  logic [HW-1:0] hcnt;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] pcnt;

  logic in_set, busy, mode_req, tout, go;
  logic rep_fire, inc_ev, accept, enter_set;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk  (clk),
    .rst  (rst),
    .raw  (key_mode),
    .db   (db_mode),
    .rise (mode_rise)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk  (clk),
    .rst  (rst),
    .raw  (key_inc),
    .db   (db_inc),
    .rise (inc_rise)
  );

  // busy: set_clk stays high after this edge, so selects must hold
  assign in_set    = (state != S_RUN);
  assign busy      = (pcnt > PW'(SET_PULSE_GAP));
  assign mode_req  = mode_rise || mode_pend;
  assign tout      = in_set && (tcnt >= TW'(TIMEOUT_CYC - 1));
  assign go        = (mode_req || tout) && !busy;
  assign rep_fire  = db_inc &&
                     ((hcnt == HW'(HOLD_CYC - 1)) ||
                      ((hcnt == HW'(HOLD_CYC)) &&
                       (rcnt == RW'(REP_CYC - 1))));
  assign inc_ev    = in_set && (inc_rise || rep_fire) && !mode_req;
  assign accept    = inc_ev && !go && !chg_q && (pcnt == '0);
  assign enter_set = go && (state_nxt != S_RUN);

  always_comb begin
    state_nxt = state;
    if (go) state_nxt = mode_req ? next_state(state) : S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      set_clr   <= 1'b0;
      set_hour  <= 1'b0;
      set_min   <= 1'b0;
      set_sec   <= 1'b0;
      set_clk   <= 1'b0;
      blink     <= 1'b0;
      mode_pend <= 1'b0;
      chg_q     <= 1'b0;
      hcnt      <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      pcnt      <= '0;
    end else begin
      state     <= state_nxt;
      set_clr   <= (state_nxt != S_RUN);
      set_hour  <= (state_nxt == S_HOUR);
      set_min   <= (state_nxt == S_MIN);
      set_sec   <= (state_nxt == S_SEC);
      mode_pend <= mode_req && busy;
      chg_q     <= go;
      set_clk   <= accept || busy;

      if (accept)
        pcnt <= PW'(SET_PULSE_HI + SET_PULSE_GAP - 1);
      else if (pcnt != '0)
        pcnt <= pcnt - 1'b1;

      if (!db_inc) begin
        hcnt <= '0;
        rcnt <= '0;
      end else if (hcnt != HW'(HOLD_CYC)) begin
        hcnt <= hcnt + 1'b1;
        rcnt <= '0;
      end else if (rcnt == RW'(REP_CYC - 1)) begin
        rcnt <= '0;
      end else begin
        rcnt <= rcnt + 1'b1;
      end

      if (state_nxt == S_RUN || enter_set || mode_rise || inc_rise)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC))
        tcnt <= tcnt + 1'b1;

      // edits restart the phase so the changed digit is shown lit
      if (state_nxt == S_RUN) begin
        blink <= 1'b0;
        bcnt  <= '0;
      end else if (enter_set || inc_ev) begin
        blink <= 1'b1;
        bcnt  <= '0;
      end else if (bcnt == BW'(BLINK_HALF - 1)) begin
        blink <= ~blink;
        bcnt  <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/timeout.
// Outputs are sampled on the falling clock edge.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_mode = 1'b0;
  logic key_inc = 1'b0;
  logic set_clr, set_hour, set_min, set_sec, set_clk, blink;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;
  int nrise = 0;
  int nhigh = 0;
  int t0 = 0;
  logic prev = 1'b0;
  int rises[$];
  int exp3[6] = '{4, 24, 32, 40, 48, 56};

  clock_set_ctrl #(
    .DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(8),
    .TIMEOUT_CYC(100), .BLINK_HALF(5)
  ) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_inc(key_inc),
    .set_clr(set_clr), .set_hour(set_hour),
    .set_min(set_min), .set_sec(set_sec),
    .set_clk(set_clk), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    tcyc++;
    if (set_clk && !prev) begin
      nrise++;
      rises.push_back(tcyc);
    end
    if (set_clk) nhigh++;
    prev = set_clk;
  endtask

  function automatic logic [5:0] outs();
    return {set_clr, set_hour, set_min, set_sec, set_clk, blink};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    nrise = 0;
    nhigh = 0;
    rises.delete();
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    repeat (4) tick();
    key_mode = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset", outs(), 6'b000000);
    rst = 1'b1;
    tick();

    // 1: mode FSM walk, debounce latency, blink phase
    key_mode = 1'b1;
    repeat (3) tick();
    chk("mode_lat3", outs(), 6'b000000);
    tick();
    chk("hour", outs(), 6'b110001);
    repeat (4) tick();
    chk("blink_hi", blink, 1);
    tick();
    chk("blink_lo", blink, 0);
    tick();
    key_mode = 1'b0;
    repeat (6) tick();
    key_mode = 1'b1;
    repeat (4) tick();
    chk("min", outs(), 6'b101001);
    key_mode = 1'b0;
    repeat (6) tick();
    key_mode = 1'b1;
    repeat (4) tick();
    chk("sec", outs(), 6'b100101);
    key_mode = 1'b0;
    repeat (6) tick();
    key_mode = 1'b1;
    repeat (4) tick();
    chk("run", outs(), 6'b000000);
    key_mode = 1'b0;
    repeat (6) tick();

    // 2: bouncy inc in S_MIN gives one clean pulse
    press_mode();
    press_mode();
    chk("in_min", outs() >> 2, 4'b1010);
    clr_cnt();
    for (int i = 0; i < 3; i++) begin
      key_inc = 1'b1;
      repeat (2) tick();
      key_inc = 1'b0;
      repeat (2) tick();
    end
    key_inc = 1'b1;
    repeat (3) tick();
    chk("bnc_pre", set_clk, 0);
    tick();
    chk("bnc_hi1", set_clk, 1);
    tick();
    chk("bnc_hi2", set_clk, 1);
    tick();
    chk("bnc_lo", set_clk, 0);
    key_inc = 1'b0;
    repeat (8) tick();
    chk("bnc_npulse", nrise, 1);
    chk("bnc_nhigh", nhigh, 2);

    // 3: hold-to-repeat in S_SEC
    press_mode();
    chk("in_sec", outs() >> 2, 4'b1001);
    clr_cnt();
    t0 = tcyc;
    key_inc = 1'b1;
    repeat (60) tick();
    key_inc = 1'b0;
    chk("rep_npulse", nrise, 6);
    chk("rep_nhigh", nhigh, 12);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rep_at%0d", i),
          (i < rises.size()) ? rises[i] - t0 : -1, exp3[i]);
    repeat (10) tick();

    // 4: timeout back to RUN, inc ignored in RUN
    press_mode();
    chk("back_run", outs(), 6'b000000);
    press_mode();
    chk("to_hour", outs() >> 2, 4'b1100);
    repeat (93) tick();
    chk("to_e99", outs() >> 2, 4'b1100);
    tick();
    chk("to_e100", outs(), 6'b000000);
    clr_cnt();
    key_inc = 1'b1;
    repeat (6) tick();
    key_inc = 1'b0;
    repeat (6) tick();
    chk("run_inc", nrise, 0);

    // 5: mode and inc together: mode wins
    press_mode();
    clr_cnt();
    key_mode = 1'b1;
    key_inc = 1'b1;
    repeat (4) tick();
    chk("both_min", outs() >> 1, 5'b10100);
    key_mode = 1'b0;
    key_inc = 1'b0;
    repeat (8) tick();
    chk("both_nopulse", nrise, 0);
    chk("both_state", outs() >> 2, 4'b1010);

    // 6: reset in the middle of a pulse
    key_inc = 1'b1;
    repeat (4) tick();
    chk("pre_rst_clk", set_clk, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst", outs(), 6'b000000);
    rst = 1'b1;
    key_inc = 1'b0;
    repeat (6) tick();
    key_mode = 1'b1;
    repeat (4) tick();
    chk("post_rst_hour", outs(), 6'b110001);
    key_mode = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
